// File: rtl/cpu_to_fpga_dsc_reader_if.sv
// Bus bundle for the descriptor reader: the PCIe BAS read master port plus the
// descriptor stream toward the TX pipeline. The reader uses "master", the host/pipeline side uses "slave".
interface cpu_to_fpga_dsc_reader_if;
  logic         pcie_bas_waitrequest;
  logic [63:0]  pcie_bas_address;
  logic [63:0]  pcie_bas_byteenable;
  logic         pcie_bas_read;
  logic [3:0]   pcie_bas_burstcount;
  logic [511:0] pcie_bas_readdata;
  logic         pcie_bas_readdatavalid;
  logic [1:0]   pcie_bas_response;
  logic         pcie_bas_write;
  logic [511:0] out_dsc_data;
  logic         out_dsc_valid;
  logic         out_dsc_ready;

  modport master (
    output pcie_bas_address, pcie_bas_byteenable, pcie_bas_read, pcie_bas_burstcount,
           pcie_bas_write, out_dsc_data, out_dsc_valid,
    input  pcie_bas_waitrequest, pcie_bas_readdata, pcie_bas_readdatavalid,
           pcie_bas_response, out_dsc_ready
  );

  modport slave (
    input  pcie_bas_address, pcie_bas_byteenable, pcie_bas_read, pcie_bas_burstcount,
           pcie_bas_write, out_dsc_data, out_dsc_valid,
    output pcie_bas_waitrequest, pcie_bas_readdata, pcie_bas_readdatavalid,
           pcie_bas_response, out_dsc_ready
  );
endinterface

// File: rtl/cpu_to_fpga_dsc_reader.sv
// Fetches 64 B TX descriptors from a host ring with BAS burst reads and streams them
// out through a credit-protected FIFO; head tracks the next descriptor to request.
//
// state | meaning
// IDLE  | evaluate pending/credit, latch next burst when one can be issued
// REQ   | read presented on BAS, held until waitrequest drops
module cpu_to_fpga_dsc_reader #(
  parameter int FIFO_DEPTH = 32,
  parameter int MAX_BURST  = 8
) (
  input  logic        pcie_clk,
  input  logic        pcie_reset_n,
  input  logic        enable,
  input  logic [63:0] rb_buf_addr,
  input  logic [25:0] rb_size,
  input  logic        tail_wr_en,
  input  logic [25:0] tail_wr_data,
  cpu_to_fpga_dsc_reader_if.master bus,
  output logic [25:0] head,
  output logic [31:0] rd_err_cnt
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [3:0] MAX_B = 4'(MAX_BURST);

  typedef enum logic {IDLE, REQ} state_t;
  state_t state, state_next;

  logic [25:0]  tail;
  logic [25:0]  ring_mask;
  logic [25:0]  pending;
  logic [3:0]   block_room;
  logic [3:0]   burst;
  logic [CW-1:0] outstanding;
  logic [CW:0]  credit_need;
  logic         credit_ok;
  logic         issue;
  logic         accept;
  logic         push;
  logic         pop;
  logic [63:0]  address;
  logic [3:0]   burstcount;
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic [511:0] mem [FIFO_DEPTH];

  assign ring_mask  = rb_size - 26'd1;
  assign pending    = (tail - head) & ring_mask;
  assign block_room = 4'd8 - {1'b0, head[2:0]};

  // Clipping to the 512 B block also keeps a burst from running past the ring end.
  always_comb begin
    burst = block_room;
    if (MAX_B < burst) burst = MAX_B;
    if (pending < 26'(burst)) burst = pending[3:0];
  end

  assign credit_need = (CW+1)'(outstanding) + (CW+1)'(burst);
  assign credit_ok   = credit_need <= (CW+1)'(FIFO_DEPTH);

  always_ff @(posedge pcie_clk) begin
    if (!pcie_reset_n) state <= IDLE;
    else               state <= state_next;
  end

  always_comb begin
    state_next = state;
    issue      = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (enable && pending != 26'd0 && credit_ok) begin
          issue      = 1'b1;
          state_next = REQ;
        end
      end
      REQ: begin
        if (!bus.pcie_bas_waitrequest) begin
          accept     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // A disable seen in REQ takes effect once the request has been accepted and we are back in IDLE.
  always_ff @(posedge pcie_clk) begin
    if (!pcie_reset_n) begin
      address    <= 64'd0;
      burstcount <= 4'd0;
      head       <= 26'd0;
      tail       <= 26'd0;
    end else begin
      if (issue) begin
        address    <= rb_buf_addr + {32'd0, head, 6'd0};
        burstcount <= burst;
      end
      if (accept) head <= (head + 26'(burstcount)) & ring_mask;
      else if (state == IDLE && !enable) head <= 26'd0;
      if (state == IDLE && !enable) tail <= 26'd0;
      else if (tail_wr_en && enable) tail <= tail_wr_data & ring_mask;
    end
  end

  always_ff @(posedge pcie_clk) begin
    if (!pcie_reset_n) outstanding <= '0;
    else outstanding <= outstanding + (accept ? CW'(burstcount) : CW'(0)) - CW'(pop);
  end

  assign push = bus.pcie_bas_readdatavalid;
  assign pop  = bus.out_dsc_valid && bus.out_dsc_ready;

  always_ff @(posedge pcie_clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= bus.pcie_bas_readdata;
  end

  always_ff @(posedge pcie_clk) begin
    if (!pcie_reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge pcie_clk) begin
    if (!pcie_reset_n) rd_err_cnt <= 32'd0;
    else if (push && bus.pcie_bas_response != 2'b00 && rd_err_cnt != 32'hFFFF_FFFF)
      rd_err_cnt <= rd_err_cnt + 32'd1;
  end

  assign bus.pcie_bas_read       = (state == REQ);
  assign bus.pcie_bas_address    = address;
  assign bus.pcie_bas_burstcount = burstcount;
  assign bus.pcie_bas_byteenable = {64{1'b1}};
  assign bus.pcie_bas_write      = 1'b0;
  assign bus.out_dsc_valid       = (wr_ptr != rd_ptr);
  assign bus.out_dsc_data        = mem[rd_ptr[AW-1:0]];
endmodule

// File: doc/cpu_to_fpga_dsc_reader.md
# cpu_to_fpga_dsc_reader

Host-to-FPGA descriptor fetcher: the CPU-to-FPGA counterpart of the FPGA-to-CPU descriptor/packet writer path. Software advances a TX descriptor ring tail via MMIO. The block issues Avalon-MM burst reads on the PCIe BAS interface to pull 64 B descriptors from host memory, buffers them in a credit-protected FIFO, and presents them as a valid/ready stream to the downstream TX pipeline. It exports the consumed-head pointer for MMIO readback.

## Interface
Parameters:
- FIFO_DEPTH, 32: descriptor FIFO entries (512-bit each); power of two, ≥ MAX_BURST.
- MAX_BURST, 8: maximum beats per read burst; ≤ 8.

Ports:
- pcie_clk  in  1  sole clock.
- pcie_reset_n  in  1  synchronous, active-low reset.
- enable  in  1  ring enable; while 0, head/tail held at 0 and no new reads are issued.
- rb_buf_addr  in  64  host byte address of ring base; 512 B aligned.
- rb_size  in  26  ring size in descriptors; power of two, ≥ 8.
- tail_wr_en  in  1  MMIO tail update strobe.
- tail_wr_data  in  26  new tail, in descriptors.
- pcie_bas_waitrequest  in  1  BAS backpressure.
- pcie_bas_address  out  64  read byte address.
- pcie_bas_byteenable  out  64  always all ones when pcie_bas_read is 1.
- pcie_bas_read  out  1  read request.
- pcie_bas_burstcount  out  4  beats in this burst (1..MAX_BURST).
- pcie_bas_readdata  in  512  returned beat.
- pcie_bas_readdatavalid  in  1  returned beat valid.
- pcie_bas_response  in  2  beat status; nonzero is an error.
- pcie_bas_write  out  1  tied 0.
- out_dsc_data  out  512  descriptor.
- out_dsc_valid  out  1  descriptor valid.
- out_dsc_ready  in  1  downstream ready.
- head  out  26  next descriptor index to be requested.
- rd_err_cnt  out  32  count of beats with nonzero response; saturating.

## Operation
- **Tail capture:** on tail_wr_en with enable=1, tail <= tail_wr_data & (rb_size-1). Ignored when enable=0.
- **Pending count:** pending = (tail - head) & (rb_size-1).
- **Burst length:** burst = min(pending, MAX_BURST, 8 - head[2:0]). Bursts never cross a 512 B boundary, so they never wrap past the ring end.
- **Credit:** outstanding = beats issued but not yet popped from the FIFO. Issue only if outstanding + burst ≤ FIFO_DEPTH, which guarantees the FIFO never overflows.
- **FSM:**
  - IDLE: if enable && pending != 0 && credit OK, latch address = rb_buf_addr + head·64 and burstcount = burst, assert read, go to REQ.
  - REQ: hold address, burstcount and read stable while waitrequest=1. On the cycle read=1 && waitrequest=0, the request is accepted: head <= (head + burst) & (rb_size-1), outstanding += burst, go to IDLE.
- **Returned beats:** each readdatavalid beat is pushed to the FIFO in order. If response != 0, rd_err_cnt increments; the data is still forwarded.
- **Output handshake:** a FIFO pop occurs when out_dsc_valid && out_dsc_ready; outstanding decrements by 1 on each pop. An accept and a pop in the same cycle net to outstanding + burst - 1.
- **Disable:** enable=0 in IDLE clears head and tail to 0. A request in REQ is completed (never dropped mid-handshake), then head/tail are cleared. In-flight beats are still delivered downstream.
- **Reset values** (pcie_reset_n=0 at an edge): FSM=IDLE, head=0, tail=0, outstanding=0, FIFO empty, pcie_bas_read=0, pcie_bas_write=0, out_dsc_valid=0, rd_err_cnt=0, address=0, burstcount=0. A reset mid-burst abandons in-flight beats; the integrating logic must hold reset until the BAS side is quiescent.

## Timing
- tail_wr_en at edge N: tail updated at N+1, pcie_bas_read=1 at N+2 (if credit and enable allow).
- Only one request is presented at a time. With waitrequest=0, back-to-back bursts are issued every 2 cycles (REQ → IDLE → REQ).
- readdatavalid beat at edge M: out_dsc_valid=1 from M+1.
- Sustained output rate is 1 descriptor/cycle when out_dsc_ready=1.
- head changes only on request acceptance.
- rd_err_cnt updates 1 cycle after the erroneous beat.

## Test plan
- **Basic fetch:** rb_size=64, base=0x1000, tail write 5 → one read, address 0x1000, burstcount 5; return 5 beats → 5 descriptors out, in order; head=5.
- **Alignment split:** head=6, tail=20 → bursts of 2 (addr base+0x180), 8 (base+0x200), 4 (base+0x400); head=20.
- **Wrap-around:** rb_size=16, head=12, tail=3 → bursts of 4 at base+0x300, then 3 at base+0x000; head=3.
- **Backpressure:** FIFO_DEPTH=32, out_dsc_ready=0, tail=40 → exactly 32 beats requested and no further read. Raising ready releases the remaining 8; no loss or duplication. waitrequest held 5 cycles → address/burstcount stable throughout.
- **Error response:** beat 2 of 4 has response=2'b10 → rd_err_cnt=1, all 4 descriptors still forwarded.
- **Disable and reset:** enable dropped during REQ → request completes, beats delivered, then head=tail=0; tail writes ignored while disabled. Synchronous reset asserted mid-stream → all outputs at reset values on the next edge.
